motion_sequencer: RTL and testbench
===================================

# motion_sequencer

Sample-clock generator and segment scheduler for the `axis` motion engines. It produces the four single-cycle phase strobes that all axes share, and it collects per-axis move parameters from a command stream into a staged segment. Once every axis is idle, it programs all staged axes together so they start on the same sample. It sits between the host/command interface and the array of `axis` instances.

## Interface
- `NAXES`, 6: number of axis engines driven; 1..8.
- `SAMPLE_DIV`, 2500: clocks per motion sample; must be ≥ 4.
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `enable`  in  1  run phase generator; low holds divider at 0, no strobes
- `ph1`,`ph2`,`ph3`,`ph4`  out  1 each  phase strobes to all axes
- `cmdValid`  in  1  command entry valid
- `cmdReady`  out  1  entry accepted when `cmdValid && cmdReady`
- `cmdAxis`  in  3  target axis index
- `cmdLast`  in  1  final entry of a segment
- `cmdDirection`  in  2  signed direction
- `cmdAcceleration`  in  32  signed acceleration
- `cmdAccelSamples`, `cmdCruiseSamples`  in  32 each  sample counts
- `prgmReq`  out  NAXES  per-axis program request
- `prgmAck`  in  NAXES  per-axis acknowledge
- `axisBusy`  in  NAXES  per-axis busy
- `prgmDirection`  out  2·NAXES  packed, axis i at [2i+1:2i]
- `prgmAcceleration`, `prgmAccelSamples`, `prgmCruiseSamples`  out  32·NAXES each  packed, axis i at [32i+31:32i]
- `busy`  out  1  state ≠ LOAD, or any `axisBusy`
- `segCount`  out  16  segments issued, wraps
- `errBadAxis`  out  1  sticky; entry with `cmdAxis ≥ NAXES` seen

## Operation
- **Phase generator:** divider `div` counts 0..SAMPLE_DIV−1, then wraps.
  - `ph1` at div=0, `ph2` at 1, `ph3` at 2, `ph4` at 3. Strobes are registered, one clock each, and mutually exclusive.
  - `enable` low: `div` is forced to 0 and all strobes are low. When `enable` rises, `ph1` occurs on the next clock after `div` reaches 0.
- **FSM states:** LOAD, WAIT_IDLE, ISSUE.
- **LOAD:**
  - `cmdReady`=1.
  - Accepted entry with a valid axis writes that axis's staging registers and sets `staged[cmdAxis]`. A duplicate axis in the same segment overwrites the earlier entry.
  - `cmdAxis ≥ NAXES`: entry is dropped and `errBadAxis` is set.
  - `cmdLast` accepted: go to WAIT_IDLE if `staged` (including this entry) is nonzero; otherwise stay in LOAD.
- **WAIT_IDLE:**
  - `cmdReady`=0.
  - When `axisBusy`==0 for all axes, set `prgmReq` = `staged` and go to ISSUE.
- **ISSUE:**
  - Hold `prgmReq[i]` until `prgmAck[i]` is seen, then clear bit i the next clock.
  - When all bits are clear (no req outstanding), clear `staged`, increment `segCount`, and return to LOAD.
- **Parameter outputs:** `prgm*` outputs are the staging registers driven continuously. They are stable from staging through ISSUE.
- Unstaged axes never see `prgmReq`, and their staging contents are don't-care.
- `segCount` wraps 0xFFFF→0.
- **Reset:**
  - Applies at any time, including mid-ISSUE.
  - Clears `div`, strobes, FSM→LOAD, `staged`, `prgmReq`, all staging registers, `segCount`, and `errBadAxis`.
  - `cmdReady`=1 after reset; all other outputs are 0.

## Timing
- Axes latch `prgmReq` on `ph4` and return ack the clock after `ph4`. All staged axes therefore ack on the same clock and start the same sample.
- Axis busy drops the clock after `ph1`. WAIT_IDLE sees it on the `ph2` cycle and drives `prgmReq` on the `ph3` cycle, so the same sample's `ph4` accepts it. There is zero idle samples between back-to-back segments.
- `prgmReq` deasserts the clock after ack, before the next `ph4`, so no double-programming occurs.
- `busy` is registered and combined with `axisBusy`, one clock latency.
- LOAD accepts one entry per clock.

## Test plan
- **Phase generator:** SAMPLE_DIV=8, enable=1 → `ph1..ph4` pulse at div 0..3 every 8 clocks. Drop `enable` mid-period → strobes stop and `div`=0.
- **Single-axis segment:** axis 2 entry (dir=1, accel=0x1000, accelSamples=3, cruise=2) with `cmdLast`, axes idle → `prgmReq`=0b000100 on the cycle before `ph4`, ack follows, `segCount`=1.
- **Multi-axis segment:** entries for axes 0, 3, 5 (last on 5) → one `ph4` acks all three simultaneously; `prgmReq` clears and FSM returns to LOAD.
- **Back-to-back segments:** second segment staged while axes are busy → WAIT_IDLE holds until busy drops; issue lands on the same sample's `ph4`, with no gap sample.
- **Bad and duplicate axes:** `cmdAxis`=7 with `cmdLast` and empty staged → `errBadAxis`=1, no req, stays in LOAD. Duplicate axis 1 with accel 5 then 9 → accel 9 is issued.
- **Reset mid-operation:** `rst` while in ISSUE with req outstanding → next clock `prgmReq`=0, `segCount`=0, `cmdReady`=1, no strobes until `div` restarts.

Source files
------------

// File: rtl/motion_sequencer.sv
// Sample-phase strobe generator plus segment scheduler: stages per-axis move
// parameters from a command stream and programs all staged axes on one sample.
module motion_sequencer #(
  parameter int NAXES      = 6,
  parameter int SAMPLE_DIV = 2500
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable_i,
  output logic                  ph1_o,
  output logic                  ph2_o,
  output logic                  ph3_o,
  output logic                  ph4_o,
  input  logic                  cmdValid_i,
  output logic                  cmdReady_o,
  input  logic [2:0]            cmdAxis_i,
  input  logic                  cmdLast_i,
  input  logic [1:0]            cmdDirection_i,
  input  logic [31:0]           cmdAcceleration_i,
  input  logic [31:0]           cmdAccelSamples_i,
  input  logic [31:0]           cmdCruiseSamples_i,
  output logic [NAXES-1:0]      prgmReq_o,
  input  logic [NAXES-1:0]      prgmAck_i,
  input  logic [NAXES-1:0]      axisBusy_i,
  output logic [2*NAXES-1:0]    prgmDirection_o,
  output logic [32*NAXES-1:0]   prgmAcceleration_o,
  output logic [32*NAXES-1:0]   prgmAccelSamples_o,
  output logic [32*NAXES-1:0]   prgmCruiseSamples_o,
  output logic                  busy_o,
  output logic [15:0]           segCount_o,
  output logic                  errBadAxis_o
);

  localparam int DIVW = $clog2(SAMPLE_DIV);

  typedef enum logic [1:0] {LOAD, WAIT_IDLE, ISSUE} state_e;

  state_e                  state_q, state_d;
  logic [DIVW-1:0]         div_q, div_d;
  logic [3:0]              ph_q, ph_d;
  logic [NAXES-1:0]        staged_q, staged_d;
  logic [NAXES-1:0]        req_q, req_d;
  logic [NAXES-1:0][1:0]   dir_q, dir_d;
  logic [NAXES-1:0][31:0]  acc_q, acc_d;
  logic [NAXES-1:0][31:0]  accSmp_q, accSmp_d;
  logic [NAXES-1:0][31:0]  cruSmp_q, cruSmp_d;
  logic [15:0]             seg_q, seg_d;
  logic                    err_q, err_d;
  logic                    busy_q, busy_d;
  logic                    accept;
  logic [NAXES-1:0]        hit;

  // Strobes are decoded from the current divider value and registered, so
  // each phase appears one clock after the divider passes its slot.
  always_comb begin
    div_d = '0;
    ph_d  = '0;
    if (enable_i) begin
      div_d = (div_q == DIVW'(SAMPLE_DIV - 1)) ? '0 : div_q + 1'b1;
      ph_d[0] = (div_q == DIVW'(0));
      ph_d[1] = (div_q == DIVW'(1));
      ph_d[2] = (div_q == DIVW'(2));
      ph_d[3] = (div_q == DIVW'(3));
    end
  end

  // Command decode: an entry whose axis matches no engine sets the error flag.
  always_comb begin
    accept = (state_q == LOAD) && cmdValid_i;
    for (int i = 0; i < NAXES; i++) begin
      hit[i] = accept && (cmdAxis_i == 3'(i));
    end
  end

  always_comb begin
    state_d  = state_q;
    staged_d = staged_q;
    req_d    = req_q;
    dir_d    = dir_q;
    acc_d    = acc_q;
    accSmp_d = accSmp_q;
    cruSmp_d = cruSmp_q;
    seg_d    = seg_q;
    err_d    = err_q;

    for (int i = 0; i < NAXES; i++) begin
      if (hit[i]) begin
        staged_d[i] = 1'b1;
        dir_d[i]    = cmdDirection_i;
        acc_d[i]    = cmdAcceleration_i;
        accSmp_d[i] = cmdAccelSamples_i;
        cruSmp_d[i] = cmdCruiseSamples_i;
      end
    end
    if (accept && (hit == '0)) begin
      err_d = 1'b1;
    end

    case (state_q)
      LOAD: begin
        if (accept && cmdLast_i && (staged_d != '0)) begin
          state_d = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (axisBusy_i == '0) begin
          req_d   = staged_q;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (req_q == '0) begin
          staged_d = '0;
          seg_d    = seg_q + 16'd1;
          state_d  = LOAD;
        end else begin
          req_d = req_q & ~prgmAck_i;
        end
      end
      default: state_d = LOAD;
    endcase

    busy_d = (state_q != LOAD) || (|axisBusy_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= LOAD;
      div_q    <= '0;
      ph_q     <= '0;
      staged_q <= '0;
      req_q    <= '0;
      dir_q    <= '0;
      acc_q    <= '0;
      accSmp_q <= '0;
      cruSmp_q <= '0;
      seg_q    <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      ph_q     <= ph_d;
      staged_q <= staged_d;
      req_q    <= req_d;
      dir_q    <= dir_d;
      acc_q    <= acc_d;
      accSmp_q <= accSmp_d;
      cruSmp_q <= cruSmp_d;
      seg_q    <= seg_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  assign ph1_o               = ph_q[0];
  assign ph2_o               = ph_q[1];
  assign ph3_o               = ph_q[2];
  assign ph4_o               = ph_q[3];
  assign cmdReady_o          = (state_q == LOAD);
  assign prgmReq_o           = req_q;
  assign prgmDirection_o     = dir_q;
  assign prgmAcceleration_o  = acc_q;
  assign prgmAccelSamples_o  = accSmp_q;
  assign prgmCruiseSamples_o = cruSmp_q;
  assign busy_o              = busy_q;
  assign segCount_o          = seg_q;
  assign errBadAxis_o        = err_q;

endmodule

// File: tb/tb_motion_sequencer.sv
// Self-checking bench for motion_sequencer: behavioural axis engines plus a
// scoreboard of expected segments popped whenever a program request rises.
module tb_motion_sequencer;

  localparam int NAX  = 6;
  localparam int SDIV = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic                enable;
  logic                ph1, ph2, ph3, ph4;
  logic                cmdValid, cmdReady, cmdLast;
  logic [2:0]          cmdAxis;
  logic [1:0]          cmdDirection;
  logic [31:0]         cmdAcceleration, cmdAccelSamples, cmdCruiseSamples;
  logic [NAX-1:0]      prgmReq, prgmAck, axisBusy;
  logic [2*NAX-1:0]    prgmDirection;
  logic [32*NAX-1:0]   prgmAcceleration, prgmAccelSamples, prgmCruiseSamples;
  logic                busy, errBadAxis;
  logic [15:0]         segCount;

  motion_sequencer #(.NAXES(NAX), .SAMPLE_DIV(SDIV)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .enable_i            (enable),
    .ph1_o               (ph1),
    .ph2_o               (ph2),
    .ph3_o               (ph3),
    .ph4_o               (ph4),
    .cmdValid_i          (cmdValid),
    .cmdReady_o          (cmdReady),
    .cmdAxis_i           (cmdAxis),
    .cmdLast_i           (cmdLast),
    .cmdDirection_i      (cmdDirection),
    .cmdAcceleration_i   (cmdAcceleration),
    .cmdAccelSamples_i   (cmdAccelSamples),
    .cmdCruiseSamples_i  (cmdCruiseSamples),
    .prgmReq_o           (prgmReq),
    .prgmAck_i           (prgmAck),
    .axisBusy_i          (axisBusy),
    .prgmDirection_o     (prgmDirection),
    .prgmAcceleration_o  (prgmAcceleration),
    .prgmAccelSamples_o  (prgmAccelSamples),
    .prgmCruiseSamples_o (prgmCruiseSamples),
    .busy_o              (busy),
    .segCount_o          (segCount),
    .errBadAxis_o        (errBadAxis)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              tight;
    logic [15:0]       seg;
    logic [NAX-1:0]    mask;
    logic [2*NAX-1:0]  dir;
    logic [32*NAX-1:0] acc;
    logic [32*NAX-1:0] accS;
    logic [32*NAX-1:0] cruS;
  } exp_t;

  exp_t              sbQ[$];
  int                checks = 0;
  int                failures = 0;
  logic              noAck = 1'b0;
  logic              monEn = 1'b1;
  logic              monBusy = 1'b0;
  logic              tightNext = 1'b0;
  logic [15:0]       segExp = 16'd0;
  logic [NAX-1:0]    mMask = '0;
  logic [2*NAX-1:0]  mDir = '0;
  logic [32*NAX-1:0] mAcc = '0, mAccS = '0, mCruS = '0;
  int unsigned       leftM[NAX];

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  // Axis engines: latch the request on ph4, ack the next clock, stay busy for
  // accelSamples samples with busy falling the clock after ph1.
  always @(posedge clk) begin
    for (int i = 0; i < NAX; i++) begin
      if (rst) begin
        prgmAck[i]  <= 1'b0;
        axisBusy[i] <= 1'b0;
        leftM[i]    <= 0;
      end else begin
        prgmAck[i] <= ph4 && prgmReq[i] && !noAck;
        if (ph4 && prgmReq[i] && !noAck) begin
          axisBusy[i] <= 1'b1;
          leftM[i]    <= (prgmAccelSamples[32*i +: 32] == 0) ? 1 : prgmAccelSamples[32*i +: 32];
        end else if (ph1 && axisBusy[i]) begin
          if (leftM[i] <= 1) begin
            axisBusy[i] <= 1'b0;
            leftM[i]    <= 0;
          end else begin
            leftM[i] <= leftM[i] - 1;
          end
        end
      end
    end
  end

  task automatic applyStimulus(input int axis, input logic last, input logic [1:0] dir,
                               input logic [31:0] acc, input logic [31:0] accS, input logic [31:0] cruS);
    int waited;
    exp_t e;
    @(negedge clk);
    cmdValid         = 1'b1;
    cmdAxis          = 3'(axis);
    cmdLast          = last;
    cmdDirection     = dir;
    cmdAcceleration  = acc;
    cmdAccelSamples  = accS;
    cmdCruiseSamples = cruS;
    waited = 0;
    while (!cmdReady && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!cmdReady) begin
      checkOutput("cmdReadyTimeout", 64'(cmdReady), 64'd1);
    end else begin
      if (axis < NAX) begin
        mMask[axis]          = 1'b1;
        mDir[2*axis +: 2]    = dir;
        mAcc[32*axis +: 32]  = acc;
        mAccS[32*axis +: 32] = accS;
        mCruS[32*axis +: 32] = cruS;
      end
      if (last && mMask != '0) begin
        if (monEn) begin
          segExp = segExp + 16'd1;
          e = '{tight: tightNext, seg: segExp, mask: mMask, dir: mDir, acc: mAcc, accS: mAccS, cruS: mCruS};
          sbQ.push_back(e);
        end
        mMask = '0;
      end
    end
    @(negedge clk);
    cmdValid = 1'b0;
    cmdLast  = 1'b0;
  endtask

  task automatic waitDrain();
    int w;
    w = 0;
    while ((sbQ.size() != 0 || monBusy) && w < 600) begin
      @(negedge clk);
      w++;
    end
    checkOutput("scoreboardDrained", 64'(sbQ.size()), 64'd0);
  endtask

  // Scoreboard consumer: a rising request pops the oldest expected segment.
  initial begin : monitor
    logic [NAX-1:0] prevReq;
    exp_t e;
    int w;
    prevReq = '0;
    forever begin
      @(negedge clk);
      if (monEn && !rst && prgmReq != '0 && prevReq == '0) begin
        monBusy = 1'b1;
        if (sbQ.size() == 0) begin
          checkOutput("unexpectedIssue", 64'(prgmReq), 64'd0);
        end else begin
          e = sbQ.pop_front();
          checkOutput("reqMask", 64'(prgmReq), 64'(e.mask));
          if (e.tight) checkOutput("issueOnPh3", 64'(ph3), 64'd1);
          for (int i = 0; i < NAX; i++) begin
            if (e.mask[i]) begin
              checkOutput($sformatf("dir%0d", i), 64'(prgmDirection[2*i +: 2]), 64'(e.dir[2*i +: 2]));
              checkOutput($sformatf("acc%0d", i), 64'(prgmAcceleration[32*i +: 32]), 64'(e.acc[32*i +: 32]));
              checkOutput($sformatf("accS%0d", i), 64'(prgmAccelSamples[32*i +: 32]), 64'(e.accS[32*i +: 32]));
              checkOutput($sformatf("cruS%0d", i), 64'(prgmCruiseSamples[32*i +: 32]), 64'(e.cruS[32*i +: 32]));
            end
          end
          w = 0;
          while (!ph4 && w < 3 * SDIV) begin
            @(negedge clk);
            w++;
          end
          if (!ph4) begin
            checkOutput("ph4Timeout", 64'(ph4), 64'd1);
          end else begin
            checkOutput("reqAtPh4", 64'(prgmReq), 64'(e.mask));
            @(negedge clk);
            @(negedge clk);
            checkOutput("reqClearedAfterAck", 64'(prgmReq), 64'd0);
            w = 0;
            while (!cmdReady && w < 50) begin
              @(negedge clk);
              w++;
            end
            checkOutput("segCount", 64'(segCount), 64'(e.seg));
          end
        end
        monBusy = 1'b0;
      end
      prevReq = prgmReq;
    end
  end

  initial begin : watchdog
    #300000;
    failures++;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : stimulus
    logic [3:0] phExp;
    logic [3:0] phSeen;
    rst = 1'b1;
    enable = 1'b0;
    cmdValid = 1'b0;
    cmdAxis = '0;
    cmdLast = 1'b0;
    cmdDirection = '0;
    cmdAcceleration = '0;
    cmdAccelSamples = '0;
    cmdCruiseSamples = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    $display("[TB] reset state");
    checkOutput("rstReady", 64'(cmdReady), 64'd1);
    checkOutput("rstReq", 64'(prgmReq), 64'd0);
    checkOutput("rstSeg", 64'(segCount), 64'd0);
    checkOutput("rstErr", 64'(errBadAxis), 64'd0);
    checkOutput("rstBusy", 64'(busy), 64'd0);
    checkOutput("rstPh", 64'({ph4, ph3, ph2, ph1}), 64'd0);

    $display("[TB] phase generator");
    enable = 1'b1;
    for (int c = 0; c < 2 * SDIV; c++) begin
      @(negedge clk);
      phExp = ((c % SDIV) < 4) ? 4'(1 << (c % SDIV)) : 4'd0;
      checkOutput($sformatf("phase%0d", c), 64'({ph4, ph3, ph2, ph1}), 64'(phExp));
    end
    repeat (2) @(negedge clk);
    enable = 1'b0;
    phSeen = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      phSeen = phSeen | {ph4, ph3, ph2, ph1};
    end
    checkOutput("phDisabled", 64'(phSeen), 64'd0);
    enable = 1'b1;
    @(negedge clk);
    checkOutput("phRestart", 64'({ph4, ph3, ph2, ph1}), 64'd1);

    $display("[TB] single axis segment");
    applyStimulus(2, 1'b1, 2'b01, 32'h1000, 32'd3, 32'd2);
    waitDrain();

    $display("[TB] multi axis segment");
    applyStimulus(0, 1'b0, 2'b11, 32'hFFFF_FF38, 32'd1, 32'd4);
    applyStimulus(3, 1'b0, 2'b01, 32'h0000_0020, 32'd2, 32'd1);
    applyStimulus(5, 1'b1, 2'b11, 32'h0000_7FFF, 32'd1, 32'd0);
    waitDrain();

    $display("[TB] back-to-back segments");
    applyStimulus(1, 1'b1, 2'b01, 32'h55, 32'd2, 32'd3);
    tightNext = 1'b1;
    applyStimulus(4, 1'b1, 2'b11, 32'h66, 32'd1, 32'd1);
    tightNext = 1'b0;
    checkOutput("b2bHoldReady", 64'(cmdReady), 64'd0);
    checkOutput("b2bHoldReq", 64'(prgmReq), 64'd0);
    checkOutput("b2bBusy", 64'(busy), 64'd1);
    waitDrain();

    $display("[TB] bad and duplicate axes");
    applyStimulus(7, 1'b1, 2'b01, 32'h77, 32'd1, 32'd1);
    repeat (3) @(negedge clk);
    checkOutput("badAxisErr", 64'(errBadAxis), 64'd1);
    checkOutput("badAxisReady", 64'(cmdReady), 64'd1);
    checkOutput("badAxisNoReq", 64'(prgmReq), 64'd0);
    applyStimulus(1, 1'b0, 2'b01, 32'd5, 32'd1, 32'd2);
    applyStimulus(6, 1'b0, 2'b01, 32'd6, 32'd1, 32'd2);
    applyStimulus(1, 1'b1, 2'b11, 32'd9, 32'd1, 32'd3);
    waitDrain();

    $display("[TB] reset mid-issue");
    monEn = 1'b0;
    noAck = 1'b1;
    applyStimulus(0, 1'b1, 2'b01, 32'h11, 32'd1, 32'd1);
    repeat (3 * SDIV) @(negedge clk);
    checkOutput("reqHeldNoAck", 64'(prgmReq), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midRstReq", 64'(prgmReq), 64'd0);
    checkOutput("midRstSeg", 64'(segCount), 64'd0);
    checkOutput("midRstReady", 64'(cmdReady), 64'd1);
    checkOutput("midRstErr", 64'(errBadAxis), 64'd0);
    checkOutput("midRstPh", 64'({ph4, ph3, ph2, ph1}), 64'd0);
    @(negedge clk);
    checkOutput("midRstPhRestart", 64'({ph4, ph3, ph2, ph1}), 64'd1);
    segExp = 16'd0;
    noAck = 1'b0;
    monEn = 1'b1;
    applyStimulus(3, 1'b1, 2'b01, 32'h33, 32'd1, 32'd1);
    waitDrain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
